// File: rtl/rpn_feeder.sv
// Token FIFO and command sequencer in front of the 16-bit RPN calculator.
// Tracks a shadow stack depth so that only legal push/op commands reach the calculator.
module rpn_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          step,
    input  logic          nrst,
    input  logic          run,
    input  logic          tok_valid,
    input  logic [17:0]   tok_data,
    output logic          tok_ready,
    output logic          push,
    output logic [1:0]    op,
    output logic [15:0]   d,
    input  logic [9:0]    cnt,
    input  logic [15:0]   top,
    output logic          res_valid,
    output logic [15:0]   result,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [AW:0]   lvl,
    output logic          dbg_state
);

    // Handshake: a token transfers on a rising step edge where tok_valid && tok_ready;
    // tok_ready depends only on registered state, never on tok_valid.

    typedef enum logic {
        S_RUN = 1'b0,
        S_ERR = 1'b1
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [9:0]  DEP_MAX  = 10'd1023;

    state_t        state_q, state_d;
    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   lvl_q, lvl_d;
    logic [9:0]    dep_q, dep_d;
    logic          res_valid_q;
    logic [15:0]   result_q;
    logic          err_q;
    logic [2:0]    err_code_q;

    logic          wr, pop, err_set, end_hit;
    logic [2:0]    code;
    logic [17:0]   head;

    assign head      = mem_q[rd_ptr_q];
    assign tok_ready = (lvl_q != LVL_FULL) && (state_q == S_RUN);
    assign wr        = tok_valid && tok_ready;

    always_comb begin
        push    = 1'b0;
        op      = 2'b00;
        d       = 16'd0;
        pop     = 1'b0;
        err_set = 1'b0;
        code    = 3'd0;
        end_hit = 1'b0;
        dep_d   = dep_q;
        if (state_q == S_RUN) begin
            // A depth disagreement means the calculator and the shadow diverged; stop before issuing.
            if (cnt != dep_q) begin
                err_set = 1'b1;
                code    = 3'd5;
            end else if (run && (lvl_q != '0)) begin
                pop = 1'b1;
                case (head[17:16])
                    2'b00: begin
                        if (dep_q != DEP_MAX) begin
                            push  = 1'b1;
                            d     = head[15:0];
                            dep_d = dep_q + 10'd1;
                        end else begin
                            err_set = 1'b1;
                            code    = 3'd1;
                        end
                    end
                    2'b01: begin
                        if (head[1:0] == 2'b01) begin
                            if (dep_q == 10'd0) begin
                                err_set = 1'b1;
                                code    = 3'd2;
                            end else begin
                                op = 2'b01;
                            end
                        end else if (head[1:0] != 2'b00) begin
                            if (dep_q < 10'd2) begin
                                err_set = 1'b1;
                                code    = 3'd2;
                            end else begin
                                op    = head[1:0];
                                dep_d = dep_q - 10'd1;
                            end
                        end
                    end
                    2'b10: begin
                        if (dep_q == 10'd0) begin
                            err_set = 1'b1;
                            code    = 3'd3;
                        end else begin
                            end_hit = 1'b1;
                        end
                    end
                    default: begin
                        err_set = 1'b1;
                        code    = 3'd4;
                    end
                endcase
            end
        end
        state_d = err_set ? S_ERR : state_q;
    end

    always_comb begin
        case ({wr, pop})
            2'b10:   lvl_d = lvl_q + LVL_ONE;
            2'b01:   lvl_d = lvl_q - LVL_ONE;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge step) begin
        if (wr) mem_q[wr_ptr_q] <= tok_data;
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lvl_q       <= '0;
            dep_q       <= 10'd0;
            res_valid_q <= 1'b0;
            result_q    <= 16'd0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            dep_q       <= dep_d;
            res_valid_q <= end_hit;
            if (wr)      wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            // top already reflects every command issued before the END cycle.
            if (end_hit) result_q <= top;
            if (err_set) begin
                err_q      <= 1'b1;
                err_code_q <= code;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign lvl       = lvl_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_feeder.sv
// Directed bench for rpn_feeder with a behavioural calculator model and
// scoreboards for issued commands and END results.
module tb_rpn_feeder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          step = 1'b0;
    logic          nrst = 1'b0;
    logic          run = 1'b0;
    logic          tok_valid = 1'b0;
    logic [17:0]   tok_data = 18'd0;
    logic          tok_ready, push, res_valid, err, dbg_state;
    logic [1:0]    op;
    logic [15:0]   d, result, top;
    logic [9:0]    cnt;
    logic [2:0]    err_code;
    logic [AW:0]   lvl;

    logic          cnt_force = 1'b0;
    logic [9:0]    cnt_forced = 10'd0;
    logic [15:0]   stk [1024];
    logic [10:0]   sp;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [18:0] cmd_q[$];

    // clock / reset
    always #5 step = ~step;

    initial begin
        #(400000);
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    rpn_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .step(step), .nrst(nrst), .run(run), .tok_valid(tok_valid),
        .tok_data(tok_data), .tok_ready(tok_ready), .push(push), .op(op),
        .d(d), .cnt(cnt), .top(top), .res_valid(res_valid), .result(result),
        .err(err), .err_code(err_code), .lvl(lvl), .dbg_state(dbg_state)
    );

    // calculator model
    always @(posedge step or negedge nrst) begin
        if (!nrst) begin
            sp <= 11'd0;
        end else if (push) begin
            if (sp < 11'd1024) begin
                stk[sp[9:0]] <= d;
                sp <= sp + 11'd1;
            end
        end else if (op == 2'b01) begin
            if (sp >= 11'd1) stk[10'(sp - 11'd1)] <= 16'd0 - stk[10'(sp - 11'd1)];
        end else if (op != 2'b00) begin
            if (sp >= 11'd2) begin
                if (op == 2'b10)
                    stk[10'(sp - 11'd2)] <= stk[10'(sp - 11'd2)] + stk[10'(sp - 11'd1)];
                else
                    stk[10'(sp - 11'd2)] <= stk[10'(sp - 11'd2)] * stk[10'(sp - 11'd1)];
                sp <= sp - 11'd1;
            end
        end
    end

    assign cnt = cnt_force ? cnt_forced : sp[9:0];
    assign top = (sp != 11'd0) ? stk[10'(sp - 11'd1)] : 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitors, sampled on the falling edge
    always @(negedge step) begin
        if (nrst && (push || op != 2'b00)) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", 32'({push, op, d}), 32'd0);
            else chk("cmd", 32'({push, op, d}), 32'(cmd_q.pop_front()));
        end
        if (nrst && res_valid) begin
            if (exp_q.size() == 0) chk("res_unexpected", 32'(result), 32'hDEAD_0000);
            else chk("result", 32'(result), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks: all start and end at posedge + 1
    task automatic send(input logic [1:0] kind, input logic [15:0] payload);
        int n = 0;
        tok_valid = 1'b1;
        tok_data  = {kind, payload};
        while (!tok_ready && n < 200) begin
            @(posedge step); #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(tok_ready), 32'd1);
        @(posedge step); #1;
        tok_valid = 1'b0;
    endtask

    task automatic exp_push(input logic [15:0] v);
        cmd_q.push_back({1'b1, 2'b00, v});
    endtask

    task automatic exp_op(input logic [1:0] o);
        cmd_q.push_back({1'b0, o, 16'd0});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() + cmd_q.size()) != 0 && n < 100) begin
            @(posedge step); #1;
            n++;
        end
        chk(tag, 32'(exp_q.size() + cmd_q.size()), 32'd0);
    endtask

    task automatic wait_err(input string tag, input logic [2:0] code);
        int n = 0;
        while (!err && n < 50) begin
            @(posedge step); #1;
            n++;
        end
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_code"}, 32'(err_code), 32'(code));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_push"}, 32'(push), 32'd0);
        chk({tag, "_op"}, 32'(op), 32'd0);
        chk({tag, "_d"}, 32'(d), 32'd0);
        chk({tag, "_lvl"}, 32'(lvl), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_resv"}, 32'(res_valid), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_ready"}, 32'(tok_ready), 32'd1);
    endtask

    task automatic do_reset(input string tag);
        nrst = 1'b0;
        #1;
        check_idle_outputs(tag);
        @(posedge step); #1;
        nrst = 1'b1;
    endtask

    initial begin
        int acc;
        #1;
        check_idle_outputs("por");
        @(posedge step); #1;
        nrst = 1'b1;

        // add: 3 + 4
        run = 1'b1;
        exp_push(16'd3); exp_push(16'd4); exp_op(2'b10);
        exp_q.push_back(16'd7);
        send(2'b00, 16'd3); send(2'b00, 16'd4); send(2'b01, 16'd2); send(2'b10, 16'd0);
        drain("add_drain");
        chk("add_err", 32'(err), 32'd0);
        chk("add_cnt", 32'(cnt), 32'd1);
        chk("add_result_held", 32'(result), 32'd7);

        // neg with a no-op in between, then mul; stack from add is retained
        exp_push(16'd5); exp_op(2'b01);
        exp_q.push_back(16'hFFFB);
        send(2'b00, 16'd5); send(2'b01, 16'd0); send(2'b01, 16'd1); send(2'b10, 16'd0);
        exp_push(16'h0100); exp_push(16'h0003); exp_op(2'b11);
        exp_q.push_back(16'h0300);
        send(2'b00, 16'h0100); send(2'b00, 16'h0003); send(2'b01, 16'd3); send(2'b10, 16'd0);
        drain("negmul_drain");
        chk("negmul_cnt", 32'(cnt), 32'd3);

        // underflow freezes the FIFO
        do_reset("rst_uf");
        run = 1'b0;
        exp_push(16'd5);
        send(2'b00, 16'd5); send(2'b01, 16'd2); send(2'b00, 16'd9);
        chk("uf_lvl_before", 32'(lvl), 32'd3);
        run = 1'b1;
        wait_err("uf", 3'd2);
        chk("uf_ready", 32'(tok_ready), 32'd0);
        chk("uf_lvl", 32'(lvl), 32'd1);
        tok_valid = 1'b1;
        tok_data  = {2'b00, 16'd1};
        for (int i = 0; i < 4; i++) begin
            @(posedge step); #1;
        end
        tok_valid = 1'b0;
        chk("uf_lvl_frozen", 32'(lvl), 32'd1);
        chk("uf_push", 32'(push), 32'd0);
        chk("uf_state", 32'(dbg_state), 32'd1);
        drain("uf_drain");

        // backpressure: fill with run low, then drain one per cycle
        do_reset("rst_bp");
        run = 1'b0;
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            tok_valid = 1'b1;
            tok_data  = {2'b00, 16'(i)};
            if (tok_ready) acc++;
            @(posedge step); #1;
        end
        tok_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd8);
        chk("bp_lvl_full", 32'(lvl), 32'd8);
        chk("bp_ready_full", 32'(tok_ready), 32'd0);
        for (int i = 1; i <= 8; i++) exp_push(16'(i));
        run = 1'b1;
        @(negedge step);
        chk("bp_ready_before_pop", 32'(tok_ready), 32'd0);
        @(posedge step); #1;
        chk("bp_ready_after_pop", 32'(tok_ready), 32'd1);
        chk("bp_lvl_7", 32'(lvl), 32'd7);
        for (int k = 6; k >= 0; k--) begin
            @(posedge step); #1;
            chk("bp_lvl_step", 32'(lvl), 32'(k));
        end
        drain("bp_drain");
        chk("bp_err", 32'(err), 32'd0);

        // overflow at depth 1023
        do_reset("rst_of");
        run = 1'b1;
        for (int i = 0; i < 1023; i++) begin
            exp_push(16'(i));
            send(2'b00, 16'(i));
        end
        send(2'b00, 16'hBEEF);
        wait_err("of", 3'd1);
        drain("of_drain");
        chk("of_cnt", 32'(cnt), 32'd1023);

        // END on empty stack
        do_reset("rst_end");
        send(2'b10, 16'd0);
        wait_err("end_empty", 3'd3);
        chk("end_empty_resv", 32'(res_valid), 32'd0);

        // reserved kind
        do_reset("rst_kind");
        send(2'b11, 16'h1234);
        wait_err("kind11", 3'd4);

        // depth mismatch wins over a pending issue
        do_reset("rst_mm");
        run = 1'b0;
        send(2'b00, 16'd7);
        cnt_forced = 10'd3;
        cnt_force  = 1'b1;
        run = 1'b1;
        wait_err("mismatch", 3'd5);
        chk("mm_lvl", 32'(lvl), 32'd1);
        cnt_force = 1'b0;
        drain("mm_drain");

        // reset in the middle of a stream, then resume
        do_reset("rst_mid0");
        run = 1'b0;
        send(2'b00, 16'd1); send(2'b00, 16'd2);
        exp_push(16'd1);
        run = 1'b1;
        @(posedge step); #1;
        #1;
        nrst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(posedge step); #1;
        nrst = 1'b1;
        chk("mid_cmd_q", 32'(cmd_q.size()), 32'd0);
        exp_push(16'd2); exp_push(16'd3); exp_op(2'b11);
        exp_q.push_back(16'd6);
        send(2'b00, 16'd2); send(2'b00, 16'd3); send(2'b01, 16'd3); send(2'b10, 16'd0);
        drain("resume_drain");
        chk("resume_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpn_feeder.md
Name: rpn_feeder

Overview:
- Upstream command sequencer for the 16-bit RPN stack calculator.
- Accepts a stream of 18-bit tokens over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one push/op command per cycle to the calculator, tracking a shadow stack depth so illegal commands are never issued.
- Reports the expression result on an END token and reports errors (overflow, underflow, malformed token, depth mismatch) with a sticky error state.

Parameters:
DEPTH, 8, token FIFO entries (power of two, >=2)
AW, 3, log2(DEPTH)

Ports:
step  input  1  clock, all state changes on posedge
nrst  input  1  asynchronous active-low reset
run  input  1  1 = issue from FIFO allowed this cycle; 0 = hold (FIFO still accepts)
tok_valid  input  1  token present
tok_data  input  18  [17:16] kind, [15:0] payload
tok_ready  output  1  FIFO can accept a token
push  output  1  to calculator: push d
op  output  2  to calculator: 01 neg, 10 add, 11 mul, 00 none
d  output  16  to calculator: push data
cnt  input  10  calculator element count
top  input  16  calculator top-of-stack
res_valid  output  1  one-cycle result strobe
result  output  16  captured result
err  output  1  sticky error flag
err_code  output  3  0 none, 1 overflow, 2 underflow, 3 END on empty, 4 reserved kind, 5 depth mismatch
lvl  output  AW+1  FIFO occupancy

Behaviour:
- Reset (async, nrst=0) clears:
  - FIFO pointers, lvl=0, shadow depth dep=0.
  - res_valid=0, result=0, err=0, err_code=0, state=RUN.
  - Combinational outputs follow: push=0, op=00, d=0.
- Token kinds:
  - 00 PUSH payload.
  - 01 OP with op=payload[1:0]; payload[1:0]=00 is a no-op, popped with no command.
  - 10 END.
  - 11 reserved.
- FIFO:
  - Registered storage.
  - Write when tok_valid && tok_ready.
  - tok_ready = (lvl!=DEPTH) && state==RUN. No write when full, even if a pop occurs the same cycle.
  - Simultaneous write and pop leaves lvl unchanged.
- States are RUN and ERR.
- Issue in RUN, when run=1 && lvl!=0: decode the FIFO head combinationally and pop it at the next edge.
  - PUSH, dep<1023: push=1, d=payload; dep+1.
  - PUSH, dep==1023: error 1.
  - OP neg: needs dep>=1, else error 2; dep unchanged.
  - OP add/mul: needs dep>=2, else error 2; dep-1.
  - END, dep>=1: head popped, no command; next edge result<=top, res_valid=1 for exactly one cycle. dep unchanged, stack retained.
  - END, dep==0: error 3.
  - Kind 11: error 4.
- When not issuing (run=0, lvl=0, or ERR): push=0, op=00, d=0.
- Depth check: in RUN, every cycle cnt!=dep gives error 5, taking priority over issue that cycle.
  - dep and the calculator counter update on the same edge, so they are always equal in correct operation.
- Result timing: top reflects a command issued in cycle t during cycle t+1. An END popped in cycle t+1 therefore sees the final value.
- Error entry:
  - The offending token is popped, no command is issued, push/op=0 in that cycle.
  - Next edge: err=1, err_code set, state=ERR.
- ERR is absorbing until nrst:
  - tok_ready=0, no pops, FIFO contents and lvl frozen.
  - res_valid=0, result held.
- Reset mid-operation: all of the above clears immediately (async). The calculator shares nrst, so cnt=0 matches dep=0.
- Throughput: 1 command per cycle with FIFO non-empty and run=1.
- Latency: tok accepted at edge e is issuable in the cycle after e.

Test Plan:
- Add: tokens PUSH 3, PUSH 4, OP 10, END, run=1 -> push cycles d=3 then d=4, then op=10, dep=1; res_valid one cycle with result=7, err=0.
- Neg: PUSH 5, OP 01, END -> result=0xFFFB. Also PUSH 0x0100, PUSH 0x0003, OP 11, END -> result=0x0300.
- Underflow: PUSH 5, OP 10 -> op stays 00, next cycle err=1, err_code=2, tok_ready=0. Further tokens are not accepted and lvl is frozen.
- Backpressure: run=0, offer 10 tokens -> 8 accepted, tok_ready=0, lvl=8. Raise run -> one pop per cycle, tok_ready returns 1 the cycle after the first pop.
- Overflow: 1023 PUSHes, then 1 more -> the 1024th is not issued, err_code=1. Also END with dep=0 -> err_code=3, and kind 11 -> err_code=4.
- Mismatch and reset: force cnt=3 while dep=0 -> err_code=5. Assert nrst mid-stream -> all outputs 0 immediately, lvl=0; processing resumes normally after release.
